// File: rtl/i2c_target_regfile.sv
// I2C target with a 16 x 8 register bank, auto-incrementing register pointer
// and a combinational local read port. SCL/SDA are sampled in the clk domain.
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter logic [7:0] RESET_FILL  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  input  logic [3:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       busy,
  output logic       wr_strobe
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic       ack_ph;
  logic [3:0] ptr;
  logic [7:0] regs [16];

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // Two synchronizer stages (_p0, _p1) plus one history stage (_p2); idle-high on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_in;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  // Edge and bus-condition detection on the synchronized levels
  logic scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
  logic [7:0] rx_byte;

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign sda_rise   = sda_p1 & ~sda_p2;
  assign sda_fall   = ~sda_p1 & sda_p2;
  assign start_cond = sda_fall & scl_p1;
  assign stop_cond  = sda_rise & scl_p1;
  assign rx_byte    = {shreg[6:0], sda_p1};

  assign host_rdata = regs[host_addr];

  // Protocol FSM: START/STOP override everything; ACK states use ack_ph to
  // separate "assert ACK on first fall" from "finish ACK on second fall".
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= 3'd7;
      ack_ph        <= 1'b0;
      ptr           <= 4'd0;
      sda_drive_low <= 1'b0;
      busy          <= 1'b0;
      wr_strobe     <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= RESET_FILL;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_cond) begin
        state         <= IDLE;
        sda_drive_low <= 1'b0;
        busy          <= 1'b0;
      end else if (start_cond) begin
        state         <= ADDR;
        bit_cnt       <= 3'd7;
        sda_drive_low <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd0) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state  <= ADDR_ACK;
                rw     <= rx_byte[0];
                busy   <= 1'b1;
                ack_ph <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_drive_low <= 1'b1;
              ack_ph        <= 1'b1;
            end else begin
              ack_ph  <= 1'b0;
              bit_cnt <= 3'd7;
              if (state == ADDR_ACK && rw) begin
                shreg         <= regs[ptr];
                sda_drive_low <= ~regs[ptr][7];
                state         <= RDATA;
              end else begin
                sda_drive_low <= 1'b0;
                state         <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          PTR: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd0) begin
              ptr    <= rx_byte[3:0];
              state  <= PTR_ACK;
              ack_ph <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          WDATA: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd0) begin
              regs[ptr] <= rx_byte;
              wr_strobe <= 1'b1;
              ptr       <= ptr + 4'd1;
              state     <= WDATA_ACK;
              ack_ph    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          RDATA: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_drive_low <= 1'b0;
              ptr           <= ptr + 4'd1;
              state         <= RDATA_ACK;
              ack_ph        <= 1'b0;
            end else begin
              bit_cnt       <= bit_cnt - 3'd1;
              shreg         <= {shreg[6:0], 1'b0};
              sda_drive_low <= ~shreg[6];
            end
          end
          RDATA_ACK: begin
            if (!ack_ph) begin
              if (scl_rise) begin
                if (!sda_p1) begin
                  shreg  <= regs[ptr];
                  ack_ph <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end else if (scl_fall) begin
              sda_drive_low <= ~shreg[7];
              bit_cnt       <= 3'd7;
              ack_ph        <= 1'b0;
              state         <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged controller plus a register-bank
// reference model (array + pointer) updated per transferred byte.
module tb_i2c_target_regfile;

  localparam logic [6:0] TADDR = 7'h50;
  localparam logic [7:0] FILL  = 8'hE7;

  logic       clk = 1'b0;
  logic       rst, scl_drv, sda_drv;
  logic       scl_in, sda_in, sda_drive_low, busy, wr_strobe;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;

  int n_vec = 0, n_err = 0;
  int ph = 20;
  int strobe_cnt = 0, low_cnt = 0, busy_cnt = 0;

  logic [7:0] mem [16];
  logic [3:0] mptr;
  logic [7:0] wq [$];
  logic [7:0] rd_q [$];
  logic [7:0] r20 [2];

  always #5 clk = ~clk;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_drive_low;

  i2c_target_regfile #(.TARGET_ADDR(TADDR), .RESET_FILL(FILL)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda_drive_low(sda_drive_low), .host_addr(host_addr),
    .host_rdata(host_rdata), .busy(busy), .wr_strobe(wr_strobe)
  );

  // Event counters sampled every clock
  always @(posedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (sda_drive_low) low_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (!scl_drv) begin
      tick(ph / 2); sda_drv = 1'b1; tick(ph - ph / 2); scl_drv = 1'b1;
    end
    tick(ph); sda_drv = 1'b0; tick(ph); scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    tick(ph / 2); sda_drv = 1'b0; tick(ph - ph / 2); scl_drv = 1'b1;
    tick(ph); sda_drv = 1'b1; tick(ph);
  endtask

  task automatic put_bit(input logic b);
    tick(ph / 2); sda_drv = b; tick(ph - ph / 2); scl_drv = 1'b1;
    tick(ph); scl_drv = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    tick(ph / 2); sda_drv = 1'b1; tick(ph - ph / 2); scl_drv = 1'b1;
    tick(ph - 1); b = sda_in; tick(1); scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    ack = ~a;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      b[i] = x;
    end
    put_bit(~ack);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      #1;
      chk(tag, 32'(host_rdata), 32'(mem[i]));
    end
  endtask

  // Write transaction: address, pointer, then every byte in wq
  task automatic xfer_write(input logic [6:0] a, input logic [3:0] p, input string tag);
    logic ack, hit;
    hit = (a == TADDR);
    bus_start();
    send_byte({a, 1'b0}, ack);
    chk({tag, "_aack"}, 32'(ack), 32'(hit));
    if (hit) chk({tag, "_busy"}, 32'(busy), 32'd1);
    send_byte({4'($urandom), p}, ack);
    chk({tag, "_pack"}, 32'(ack), 32'(hit));
    if (hit) mptr = p;
    foreach (wq[i]) begin
      send_byte(wq[i], ack);
      chk({tag, "_dack"}, 32'(ack), 32'(hit));
      if (hit) begin
        mem[mptr] = wq[i];
        mptr = mptr + 4'd1;
      end
    end
    bus_stop();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Read transaction, optionally preceded by a pointer write and repeated START
  task automatic xfer_read(input logic [6:0] a, input bit set_ptr, input logic [3:0] p,
                           input int n, input string tag);
    logic ack, hit;
    logic [7:0] b;
    hit = (a == TADDR);
    rd_q.delete();
    bus_start();
    if (set_ptr) begin
      send_byte({a, 1'b0}, ack);
      chk({tag, "_wack"}, 32'(ack), 32'(hit));
      send_byte({4'h0, p}, ack);
      chk({tag, "_pack"}, 32'(ack), 32'(hit));
      if (hit) mptr = p;
      bus_start();
    end
    send_byte({a, 1'b1}, ack);
    chk({tag, "_rack"}, 32'(ack), 32'(hit));
    if (hit) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
        recv_byte(b, i != n - 1);
        rd_q.push_back(b);
        chk({tag, "_data"}, 32'(b), 32'(mem[mptr]));
        mptr = mptr + 4'd1;
      end
      chk({tag, "_nackrel"}, 32'(sda_drive_low), 32'd0);
    end
    bus_stop();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s0, l0, b0;
    logic ack;
    logic [6:0] ra;
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; host_addr = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = FILL;
    mptr = 4'd0;
    tick(3);
    chk("rst_sda", 32'(sda_drive_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrs", 32'(wr_strobe), 32'd0);
    rst = 1'b0;
    tick(2);
    check_regs("rst_reg");

    // Write burst
    ph = 20;
    s0 = strobe_cnt;
    wq = '{8'h5A, 8'hC3};
    xfer_write(TADDR, 4'h3, "wb");
    chk("wb_strobe", 32'(strobe_cnt - s0), 32'd2);
    host_addr = 4'd4; #1;
    chk("wb_peek4", 32'(host_rdata), 32'hC3);
    check_regs("wb_reg");

    // Combined read with repeated START, then current-address read at ptr 5
    xfer_read(TADDR, 1'b1, 4'h3, 2, "cr");
    r20[0] = rd_q[0]; r20[1] = rd_q[1];
    chk("cr_b0", 32'(rd_q[0]), 32'h5A);
    chk("cr_b1", 32'(rd_q[1]), 32'hC3);
    xfer_read(TADDR, 1'b0, 4'h0, 1, "cur");
    chk("cur_ptr5", 32'(rd_q[0]), 32'(FILL));

    // Address miss
    l0 = low_cnt; b0 = busy_cnt;
    wq = '{8'hFF};
    bus_start();
    send_byte(8'hA2, ack); chk("miss_a", 32'(ack), 32'd0);
    send_byte(8'h00, ack); chk("miss_p", 32'(ack), 32'd0);
    send_byte(8'hFF, ack); chk("miss_d", 32'(ack), 32'd0);
    bus_stop();
    chk("miss_low", 32'(low_cnt - l0), 32'd0);
    chk("miss_busy", 32'(busy_cnt - b0), 32'd0);
    check_regs("miss_reg");

    // Pointer wrap
    wq = '{8'h11, 8'h22};
    xfer_write(TADDR, 4'hF, "wrap");
    host_addr = 4'hF; #1; chk("wrap_r15", 32'(host_rdata), 32'h11);
    host_addr = 4'h0; #1; chk("wrap_r0", 32'(host_rdata), 32'h22);
    xfer_read(TADDR, 1'b1, 4'hF, 2, "wrapr");
    chk("wrapr_b0", 32'(rd_q[0]), 32'h11);
    chk("wrapr_b1", 32'(rd_q[1]), 32'h22);

    // STOP after 4 data bits
    s0 = strobe_cnt;
    bus_start();
    send_byte({TADDR, 1'b0}, ack); chk("ab_aack", 32'(ack), 32'd1);
    send_byte(8'h02, ack); chk("ab_pack", 32'(ack), 32'd1);
    mptr = 4'h2;
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop();
    chk("ab_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    check_regs("ab_reg");

    // Minimum SCL phase: same write/read pattern as the 20-clk run
    ph = 4;
    wq = '{8'h5A, 8'hC3};
    xfer_write(TADDR, 4'hA, "mt");
    xfer_read(TADDR, 1'b1, 4'hA, 2, "mtr");
    chk("mt_b0", 32'(rd_q[0]), 32'(r20[0]));
    chk("mt_b1", 32'(rd_q[1]), 32'(r20[1]));

    // Reset while the target drives a 0 data bit
    ph = 20;
    wq = '{8'h3C};
    xfer_write(TADDR, 4'h7, "pre");
    bus_start();
    send_byte({TADDR, 1'b0}, ack);
    send_byte(8'h07, ack);
    bus_start();
    send_byte({TADDR, 1'b1}, ack);
    chk("rr_ack", 32'(ack), 32'd1);
    tick(ph / 2);
    chk("rr_drive", 32'(sda_drive_low), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("rr_release", 32'(sda_drive_low), 32'd0);
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = FILL;
    mptr = 4'd0;
    chk("rr_busy", 32'(busy), 32'd0);
    check_regs("rr_reg");
    tick(ph / 2); sda_drv = 1'b1; tick(2); scl_drv = 1'b1; tick(ph);

    // Randomized transactions against the model
    for (int t = 0; t < 24; t++) begin
      ph = int'($urandom_range(4, 9));
      ra = TADDR;
      if ($urandom_range(0, 4) == 0) begin
        ra = 7'($urandom);
        if (ra == TADDR) ra = ra ^ 7'h01;
      end
      if ($urandom_range(0, 1) == 0) begin
        wq.delete();
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) wq.push_back(8'($urandom));
        xfer_write(ra, 4'($urandom), "rnd_w");
      end else begin
        xfer_read(ra, $urandom_range(0, 3) != 0, 4'($urandom), int'($urandom_range(1, 3)), "rnd_r");
      end
      host_addr = 4'($urandom); #1;
      chk("rnd_peek", 32'(host_rdata), 32'(mem[host_addr]));
    end
    check_regs("final_reg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (responder) for the LC-3 SDA/SCL peripheral; the LC-3 bit-bangs the controller side.
- Holds a 16 x 8 register bank, addressed by a one-byte register pointer with auto-increment.
- Sits on the board-level SDA/SCL nets. Top level wires SDA open-drain: SDA pulled to 0 when sda_drive_low=1, else high-Z.
- A local read port lets other logic and the display peek at register contents.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit I2C address this block answers to.
- RESET_FILL, 8'h00, value loaded into every register on reset.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- scl_in  input  1  raw SCL level from pin; asynchronous to clk.
- sda_in  input  1  raw SDA level from pin; asynchronous to clk.
- sda_drive_low  output  1  1 = pull SDA low; 0 = release SDA.
- host_addr  input  4  local read-port register index.
- host_rdata  output  8  register[host_addr]; combinational.
- busy  output  1  high from an addressed START until STOP or return to IDLE.
- wr_strobe  output  1  one-cycle pulse when a register is written.

Behaviour:
- Input sync and edge detection
  - scl_in and sda_in each pass through a 2-FF synchronizer, followed by one history FF.
  - scl_rise, scl_fall, sda_rise and sda_fall come from the synchronized value and its history bit.
  - Requirement on the bus: SCL high and low phases each last at least 4 clk.
- Bus conditions
  - START: sda_fall while SCL is high. STOP: sda_rise while SCL is high.
  - Both take priority over every state and are recognized anywhere, including repeated START.
- Bit timing
  - Data is sampled on scl_rise.
  - sda_drive_low changes only on the clk following an scl_fall.
  - bit_cnt (3 bits) counts 7 down to 0; data is MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: START -> ADDR, bit_cnt=7. All other bus activity is ignored.
- ADDR: shift in 8 bits.
  - On the 8th rise, compare bits[7:1] with TARGET_ADDR.
  - Match -> ADDR_ACK; latch rw=bit0; set busy=1.
  - Mismatch -> IDLE, SDA stays released.
- ADDR_ACK
  - On the next scl_fall, drive SDA low.
  - On the following scl_fall:
    - rw=0: release SDA, go to PTR.
    - rw=1: load shift register from reg[ptr], drive its MSB, go to RDATA.
- PTR: shift in 8 bits; ptr <= byte[3:0] (bits[7:4] ignored) -> PTR_ACK. ACK timing is the same as ADDR_ACK; then go to WDATA.
- WDATA
  - On the 8th rise: reg[ptr] <= byte, pulse wr_strobe for one clk, ptr <= ptr+1 (wraps 15 -> 0).
  - Go to WDATA_ACK; ACK as above; then back to WDATA.
- RDATA
  - Present bits on scl_fall: drive_low = ~bit.
  - After the 8th bit's scl_fall, release SDA; ptr <= ptr+1 (wraps); go to RDATA_ACK.
- RDATA_ACK: sample the controller's bit on scl_rise.
  - 0 (ACK): load the next byte, drive its MSB on the next scl_fall, go to RDATA.
  - 1 (NACK): go to IDLE, SDA released.
- STOP: from any state go to IDLE; sda_drive_low=0; busy=0. ptr and registers are retained.
- Repeated START: go to ADDR; SDA released the same clk; ptr retained.
- Reset values: every register = RESET_FILL; ptr=0; state=IDLE; sda_drive_low=0; busy=0; wr_strobe=0; synchronizer FFs=1 (bus idle high).
- Reset mid-transfer:
  - Aborts immediately and releases SDA.
  - A partially shifted byte is discarded.
  - The target ignores the bus until the next START.
- The host read port has no interaction with I2C writes. A write and a peek at the same index in one clk returns the old value.

Test Plan:
- Write burst: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK (SDA low) on all 4 bytes; reg3=0x5A, reg4=0xC3; wr_strobe pulses twice; host_addr=4 reads 0xC3.
- Combined read: START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (ACK then NACK), STOP -> bytes 0x5A, 0xC3; SDA released after NACK; ptr=5.
- Address miss: START, 0xA2, 0x00, 0xFF, STOP -> sda_drive_low never 1; busy stays 0; registers unchanged.
- Pointer wrap: write ptr 0x0F, data 0x11, 0x22 -> reg15=0x11, reg0=0x22. Then read from ptr 0x0F for 2 bytes -> 0x11, 0x22.
- Abort cases:
  - STOP after 4 data bits of a write -> no register change, state IDLE.
  - rst asserted during RDATA while driving low -> sda_drive_low=0 next clk; all registers=RESET_FILL.
- Minimum timing: SCL phases of exactly 4 clk with a full write/read transaction -> identical results to a 20-clk-phase run.
